// File: rtl/model_seq_pkg.sv
// model_seq_pkg: shared state encoding and default sizing for the layer sequencer
// Holds the FSM state enum, the NUM_LAYERS/CNT_W/TIMEOUT defaults and the cur_layer width.
package model_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;
    localparam int NUM_LAYERS_DEF = 4;
    localparam int CNT_W_DEF      = 24;
    localparam int TIMEOUT_DEF    = 2000000;
    localparam int LAYER_W        = $clog2(NUM_LAYERS_DEF);
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that clears synchronously and sticks at all-ones
// Ports: clk, reset (async active-low), clr (sync clear, wins over en),
//        en (count enable), cnt (current count).
module sat_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: launches a chain of layers one after another and times each one
// Ports: clk, reset (async active-low); start/clear control; busy/done/error status;
//        layer_reset/layer_valid drive each layer, layer_done returns its completion level;
//        cur_layer is the active or failing layer; total_cycles is the last run length;
//        stat_sel picks a layer whose cycle count appears on stat_cycles one cycle later.
module layer_sequencer
    import model_seq_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clear,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [NUM_LAYERS-1:0]         layer_reset,
    output logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [NUM_LAYERS-1:0]         layer_done,
    output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
    output logic [CNT_W-1:0]              total_cycles,
    input  logic [$clog2(NUM_LAYERS)-1:0] stat_sel,
    output logic [CNT_W-1:0]              stat_cycles
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam logic [NUM_LAYERS-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

    state_t state, state_d;
    logic [LW-1:0] cur_d;
    logic [NUM_LAYERS-1:0] rst_d, valid_d;
    logic launch0, advance, run;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] layer_cnt [NUM_LAYERS];

    assign run = state == RUN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_d;
    end

    // Done of the active layer is checked before the timeout so a layer finishing
    // on its last allowed cycle still advances; other layers' done bits are ignored.
    always_comb begin
        state_d = state;
        cur_d   = cur_layer;
        rst_d   = layer_reset;
        valid_d = '0;
        launch0 = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                rst_d = '1;
                cur_d = '0;
                if (start && !clear) begin
                    state_d = RUN;
                    rst_d   = ~ONE;
                    valid_d = ONE;
                    launch0 = 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    rst_d   = '1;
                    cur_d   = '0;
                end else if (layer_done[cur_layer]) begin
                    if (cur_layer == LAST) state_d = DONE;
                    else begin
                        advance = 1'b1;
                        cur_d   = cur_layer + 1'b1;
                        rst_d   = layer_reset & ~(ONE << cur_d);
                        valid_d = ONE << cur_d;
                    end
                end else if (timer == TMO_LAST) state_d = ERROR;
            end
            default: begin
                if (clear) begin
                    state_d = IDLE;
                    rst_d   = '1;
                    cur_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            layer_reset <= '1;
            layer_valid <= '0;
            cur_layer   <= '0;
            stat_cycles <= '0;
        end else begin
            busy        <= state_d == RUN;
            done        <= state_d == DONE;
            error       <= state_d == ERROR;
            layer_reset <= rst_d;
            layer_valid <= valid_d;
            cur_layer   <= cur_d;
            stat_cycles <= layer_cnt[stat_sel];
        end
    end

    // Counters run on every RUN cycle, including the one where done is sampled;
    // the timer restarts at each layer launch.
    sat_counter #(.W(CNT_W)) u_timer (
        .clk(clk), .reset(reset), .clr(launch0 | advance), .en(run), .cnt(timer)
    );

    sat_counter #(.W(CNT_W)) u_total (
        .clk(clk), .reset(reset), .clr(launch0), .en(run), .cnt(total_cycles)
    );

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk(clk), .reset(reset), .clr(launch0),
            .en(run && cur_layer == LW'(g)), .cnt(layer_cnt[g])
        );
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer with a responding layer model
module tb_layer_sequencer;
    localparam int NL = 4;
    localparam int CW = 24;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic busy, done, error;
    logic [NL-1:0] layer_reset, layer_valid;
    logic [NL-1:0] layer_done = '0;
    logic [1:0] cur_layer;
    logic [1:0] stat_sel = '0;
    logic [CW-1:0] total_cycles, stat_cycles;
    logic sat_clr = 1'b0;
    logic sat_en = 1'b0;
    logic [2:0] sat_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_LAYERS(NL), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .busy(busy), .done(done), .error(error),
        .layer_reset(layer_reset), .layer_valid(layer_valid), .layer_done(layer_done),
        .cur_layer(cur_layer), .total_cycles(total_cycles),
        .stat_sel(stat_sel), .stat_cycles(stat_cycles)
    );

    sat_counter #(.W(3)) u_sat (
        .clk(clk), .reset(reset), .clr(sat_clr), .en(sat_en), .cnt(sat_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Layer model: layer i raises a level done dly[i] cycles after its valid pulse
    // (dly < 0 = never). While held in reset it drives only the stray bit.
    int dly [NL];
    logic [NL-1:0] stray = '0;
    int age [NL];

    initial begin
        for (int i = 0; i < NL; i++) begin
            age[i] = -1;
            dly[i] = -1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (layer_reset[i]) age[i] = -1;
                else if (layer_valid[i]) age[i] = 0;
                else if (age[i] >= 0) age[i]++;
                layer_done[i] = layer_reset[i] ? stray[i] : (dly[i] >= 0 && age[i] >= dly[i]);
            end
        end
    end

    int vlog[$];
    logic [NL-1:0] vprev = '0;

    initial forever begin
        @(negedge clk);
        if (|layer_valid) begin
            chk("valid_onehot", $countones(layer_valid), 1);
            chk("valid_1cyc", layer_valid & vprev, 0);
            for (int i = 0; i < NL; i++) if (layer_valid[i]) vlog.push_back(i);
        end
        vprev = layer_valid;
    end

    typedef struct packed {
        logic err;
        logic [1:0] layer;
        logic [2:0] nlaunch;
        logic [NL-1:0][CW-1:0] cyc;
        logic [CW-1:0] total;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t predict();
        exp_t e;
        int tot;
        e = '0;
        tot = 0;
        e.layer = 2'(NL - 1);
        e.nlaunch = 3'(NL);
        for (int i = 0; i < NL; i++) begin
            if (dly[i] < 0 || dly[i] > TO - 1) begin
                e.cyc[i] = CW'(TO);
                tot += TO;
                e.err = 1'b1;
                e.layer = 2'(i);
                e.nlaunch = 3'(i + 1);
                break;
            end
            e.cyc[i] = CW'(dly[i] + 1);
            tot += dly[i] + 1;
        end
        e.total = CW'(tot);
        return e;
    endfunction

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic run_seq(input string nm);
        exp_t e;
        int n;
        sb.push_back(predict());
        vlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(done || error) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ":finished"}, done | error, 1);
        e = sb.pop_front();
        chk({nm, ":error"}, error, e.err);
        chk({nm, ":done"}, done, !e.err);
        chk({nm, ":busy"}, busy, 0);
        chk({nm, ":cur_layer"}, cur_layer, e.layer);
        chk({nm, ":total"}, total_cycles, e.total);
        chk({nm, ":launches"}, vlog.size(), e.nlaunch);
        for (int i = 0; i < vlog.size(); i++) chk({nm, ":launch_order"}, vlog[i], i);
        for (int i = 0; i < NL; i++) begin
            stat_sel = 2'(i);
            @(negedge clk);
            chk({nm, ":stat"}, stat_cycles, e.cyc[i]);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, ":start_ignored"}, {busy, done, error}, {1'b0, !e.err, e.err});
        chk({nm, ":no_relaunch"}, layer_valid, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({nm, ":idle_status"}, {busy, done, error}, 0);
        chk({nm, ":idle_reset"}, layer_reset, 4'hF);
        chk({nm, ":idle_cur"}, cur_layer, 0);
        stat_sel = 2'd0;
        @(negedge clk);
        chk({nm, ":held_stat0"}, stat_cycles, e.cyc[0]);
        chk({nm, ":held_total"}, total_cycles, e.total);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk("rst:status", {busy, done, error}, 0);
        chk("rst:layer_reset", layer_reset, 4'hF);
        chk("rst:layer_valid", layer_valid, 0);
        chk("rst:cur_layer", cur_layer, 0);
        chk("rst:total", total_cycles, 0);
        chk("rst:stat", stat_cycles, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst:idle", busy, 0);

        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        sat_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("sat_cnt", sat_cnt, (k > 7) ? 7 : k);
        end
        sat_en = 1'b0;

        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("start_clear:busy", busy, 0);
        chk("start_clear:valid", layer_valid, 0);

        set_dly(10, 20, 30, 40);
        run_seq("nominal");
        set_dly(10, 20, -1, -1);
        run_seq("timeout");
        set_dly(5, TO - 1, 5, 5);
        run_seq("coincide");
        stray = 4'b1000;
        set_dly(10, 20, 30, 40);
        run_seq("stray");
        stray = '0;

        set_dly(10, -1, -1, -1);
        vlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cur_layer != 2'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort:reached_l1", cur_layer, 1);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort:busy", busy, 0);
        chk("abort:layer_reset", layer_reset, 4'hF);
        chk("abort:cur", cur_layer, 0);
        stat_sel = 2'd0;
        @(negedge clk);
        chk("abort:held_stat0", stat_cycles, 11);
        set_dly(10, 20, 30, 40);
        run_seq("restart");

        vlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("areset:mid_run", busy, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("areset:status", {busy, done, error}, 0);
        chk("areset:layer_reset", layer_reset, 4'hF);
        chk("areset:layer_valid", layer_valid, 0);
        chk("areset:cur", cur_layer, 0);
        chk("areset:total", total_cycles, 0);
        chk("areset:stat", stat_cycles, 0);
        @(negedge clk);
        reset = 1'b1;
        vlog.delete();
        repeat (60) @(negedge clk);
        chk("areset:no_launch", vlog.size(), 0);
        chk("areset:idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
